// File: rtl/packed_lane_accumulator.sv
// Splits packed two-lane products (A + B*2^SHIFT) into signed lanes and sums each
// lane over an in_last-delimited frame; results leave through a one-deep output register.
module packed_lane_accumulator #(
    parameter int P_W   = 33,
    parameter int SHIFT = 16,
    parameter int ACC_W = 34,
    parameter int OUT_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [P_W-1:0]   in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_a,
    output logic [OUT_W-1:0] out_b,
    output logic [CNT_W-1:0] out_cnt,
    output logic [1:0]       out_sat,
    input  logic             out_ready
);

    typedef enum logic {ACCUM_EMPTY, ACCUM_BUSY} acc_state_t;
    typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    acc_state_t              acc_state;
    out_state_t              out_state;
    logic signed [ACC_W-1:0] acc_a;
    logic signed [ACC_W-1:0] acc_b;
    logic [CNT_W-1:0]        cnt;

    logic [SHIFT-1:0]        lane_a;
    logic [SHIFT-1:0]        lane_b;
    logic signed [ACC_W-1:0] dec_a;
    logic signed [ACC_W-1:0] dec_b;
    logic signed [ACC_W-1:0] sum_a;
    logic signed [ACC_W-1:0] sum_b;
    logic [CNT_W-1:0]        cnt_inc;
    logic                    accept;
    logic                    unused_bits;

    assign unused_bits = ^in_data[P_W-1:2*SHIFT];

    // Lane A's sign bit was borrowed from lane B when the product was packed; add it back.
    assign lane_a = in_data[SHIFT-1:0];
    assign lane_b = in_data[2*SHIFT-1:SHIFT] + SHIFT'(in_data[SHIFT-1]);
    assign dec_a  = {{(ACC_W-SHIFT){lane_a[SHIFT-1]}}, lane_a};
    assign dec_b  = {{(ACC_W-SHIFT){lane_b[SHIFT-1]}}, lane_b};

    assign sum_a   = acc_a + dec_a;
    assign sum_b   = acc_b + dec_b;
    assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

    assign out_valid = (out_state == OUT_FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;

    function automatic logic [OUT_W-1:0] clamp(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX)      clamp = SAT_MAX[OUT_W-1:0];
        else if (v < SAT_MIN) clamp = SAT_MIN[OUT_W-1:0];
        else                  clamp = v[OUT_W-1:0];
    endfunction

    function automatic logic is_sat(input logic signed [ACC_W-1:0] v);
        is_sat = (v > SAT_MAX) || (v < SAT_MIN);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_state <= ACCUM_EMPTY;
            out_state <= OUT_EMPTY;
            acc_a     <= '0;
            acc_b     <= '0;
            cnt       <= '0;
            out_a     <= '0;
            out_b     <= '0;
            out_cnt   <= '0;
            out_sat   <= 2'b00;
        end else begin
            if (out_valid && out_ready) begin
                out_state <= OUT_EMPTY;
            end
            if (accept) begin
                if (in_last) begin
                    out_a     <= clamp(sum_a);
                    out_b     <= clamp(sum_b);
                    out_cnt   <= cnt_inc;
                    out_sat   <= {is_sat(sum_b), is_sat(sum_a)};
                    out_state <= OUT_FULL;
                    acc_a     <= '0;
                    acc_b     <= '0;
                    cnt       <= '0;
                    acc_state <= ACCUM_EMPTY;
                end else begin
                    acc_a     <= sum_a;
                    acc_b     <= sum_b;
                    cnt       <= cnt_inc;
                    acc_state <= ACCUM_BUSY;
                end
            end
        end
    end

endmodule

// File: tb/tb_packed_lane_accumulator.sv
// Randomized and directed frames against a lane-sum model built from 8x8 products;
// expected results are queued at issue and popped by an independent output monitor.
module tb_packed_lane_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [32:0] in_data;
    logic        in_last;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_a;
    logic [15:0] out_b;
    logic [15:0] out_cnt;
    logic [1:0]  out_sat;
    logic        out_ready;

    packed_lane_accumulator dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_a(out_a), .out_b(out_b), .out_cnt(out_cnt),
        .out_sat(out_sat), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    logic [49:0] exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          rand_bp = 0;
    longint      m_a = 0;
    longint      m_b = 0;
    int          m_n = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic longint clamp16(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Model: lane sums are plain integer sums of the products; clamp only at frame end.
    task automatic model_accept(input int a, input int b, input bit last);
        longint      sa, sb;
        logic [15:0] ca, cb, cc;
        logic [1:0]  s;
        m_a += a;
        m_b += b;
        if (m_n < 65535) m_n++;
        if (last) begin
            sa = clamp16(m_a);
            sb = clamp16(m_b);
            ca = sa[15:0];
            cb = sb[15:0];
            cc = m_n[15:0];
            s  = {sb != m_b, sa != m_a};
            exp_q.push_back({ca, cb, cc, s});
            m_a = 0;
            m_b = 0;
            m_n = 0;
        end
    endtask

    task automatic send_term(input int a, input int b, input bit last);
        longint p;
        bit     ok;
        int     waited;
        p = longint'(a) + longint'(b) * 65536;
        in_valid = 1'b1;
        in_data  = p[32:0];
        in_last  = last;
        waited   = 0;
        forever begin
            if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            waited++;
            if (waited > 200) begin
                check("accept_timeout", 64'(waited), 64'(0));
                break;
            end
        end
        if (ok) model_accept(a, b, last);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_prod(input int d, input int wa, input int wb, input bit last);
        send_term(d * wa, d * wb, last);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("queue_drained", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin : monitor
        logic [49:0] e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 64'({out_a, out_b, out_cnt, out_sat}), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("result", 64'({out_a, out_b, out_cnt, out_sat}), 64'(e));
                end
            end
        end
    end

    initial begin : stim
        int t0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_outputs", 64'({out_valid, out_a, out_b, out_cnt, out_sat}), 64'(0));
        check("reset_in_ready", 64'(in_ready), 64'(1));

        // Basic decode and one-cycle latency
        send_prod(3, 5, -7, 1'b1);
        check("latency_valid", 64'(out_valid), 64'(1));
        check("basic_packed", 64'(in_data), 64'(33'h1FFEB000F));
        drain();

        // Borrow correction: low field 0xC080
        send_prod(-128, 127, 1, 1'b1);
        check("borrow_low", 64'(in_data[15:0]), 64'(16'hC080));
        drain();

        // Saturation then a clean single-term frame
        send_prod(-128, -128, 0, 1'b0);
        send_prod(-128, -128, 0, 1'b0);
        send_prod(-128, -128, 0, 1'b1);
        send_prod(1, 1, 0, 1'b1);
        drain();

        // Backpressure: frame 1 completes into a stalled output
        out_ready = 1'b0;
        send_prod(7, 9, -3, 1'b0);
        send_prod(-5, 11, 13, 1'b1);
        in_valid = 1'b1;
        in_data  = 33'(longint'(2 * 4) + longint'(2 * -6) * 65536);
        in_last  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("stall_in_ready", 64'(in_ready), 64'(0));
            check("stall_hold", 64'({out_valid, out_a, out_b, out_cnt, out_sat}),
                  64'({1'b1, exp_q[0]}));
        end
        out_ready = 1'b1;
        #1 check("release_in_ready", 64'(in_ready), 64'(1));
        send_prod(2, 4, -6, 1'b0);
        send_prod(-3, 8, 100, 1'b1);
        drain();

        // Streaming: 8 single-term frames on consecutive cycles
        t0 = 0;
        for (int i = 0; i < 8; i++) begin
            send_prod($urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
                      $urandom_range(0, 255) - 128, 1'b1);
            t0++;
        end
        check("stream_queue", 64'(exp_q.size()), 64'(1));
        drain();

        // Reset mid-frame discards the partial frame
        send_prod(50, 60, 70, 1'b0);
        send_prod(-50, 20, 30, 1'b0);
        rst = 1'b1;
        m_a = 0; m_b = 0; m_n = 0;
        @(posedge clk);
        #1 check("rst_valid_during", 64'(out_valid), 64'(0));
        rst = 1'b0;
        @(posedge clk);
        #1 check("rst_valid_after", 64'(out_valid), 64'(0));
        send_prod(1, 10, 20, 1'b0);
        send_prod(1, 10, 20, 1'b1);
        drain();

        // Random frames with random backpressure
        rand_bp = 1;
        for (int f = 0; f < 60; f++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) begin
                send_prod(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                          int'($urandom_range(0, 255)) - 128, k == len - 1);
            end
        end
        rand_bp = 0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required finish before it");
        $fatal(1);
    end

endmodule

// File: doc/packed_lane_accumulator.md
# packed_lane_accumulator

Receive-side companion to the packed two-lane 8-bit DSP multiplier. It consumes a stream of packed 33-bit products of the form A + B·2^16, splits each one into its two signed lanes, and applies the borrow correction. It accumulates each lane separately over a frame delimited by `in_last`, then presents the two saturated lane sums with a valid/ready handshake. It sits between the packed multiplier array and the activation/requantization stage.

## Interface

Parameters:
- `P_W`, 33: packed product width; bit 32 is ignored by decode.
- `SHIFT`, 16: lane B bit offset inside the packed word.
- `ACC_W`, 34: internal per-lane accumulator width, signed.
- `OUT_W`, 16: output lane width, signed, saturating.
- `CNT_W`, 16: term counter width.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  packed product present.
- `in_data`  in  `P_W`  packed product, signed.
- `in_last`  in  1  this term closes the frame.
- `in_ready`  out  1  block accepts the term this cycle.
- `out_valid`  out  1  frame result held.
- `out_a`  out  `OUT_W`  lane A sum, signed, saturated.
- `out_b`  out  `OUT_W`  lane B sum, signed, saturated.
- `out_cnt`  out  `CNT_W`  number of terms in the frame; saturates at all-ones.
- `out_sat`  out  2  [0] = lane A saturated, [1] = lane B saturated.
- `out_ready`  in  1  downstream takes the result.

## Operation

- **Accept rule.** A term is accepted when `in_valid && in_ready`.
- **Decode, per accepted term (combinational).**
  - `a = sext(in_data[SHIFT-1:0])`.
  - `b = in_data[2·SHIFT-1:SHIFT] + in_data[SHIFT-1]`, computed 16-bit, then sign-extended.
  - Decode is exact for all 8×8 packed products.
- **Accumulate.** `acc_a += a`, `acc_b += b`, `cnt += 1`. The counter holds at its maximum and does not wrap.
- **States.**
  - ACCUM_EMPTY: `cnt == 0`.
  - ACCUM_BUSY: `cnt > 0`.
  - Output register: EMPTY or FULL.
  - The accumulator state and the output-register state are independent.
- **Transitions.**
  - An accepted non-last term moves the accumulator to BUSY.
  - An accepted last term does all of the following in the same cycle:
    - loads the output register with `sat(acc_a + a)`, `sat(acc_b + b)`, `cnt + 1` and the saturation flags;
    - clears the accumulators and `cnt` (the next frame starts at 0);
    - sets the output register to FULL.
- **Single-term frame.** `in_last` arriving with `cnt == 0` outputs the decoded term directly, with `out_cnt = 1`.
- **Saturation.**
  - A full-precision lane sum above 2^(OUT_W−1)−1 clamps to the maximum; below −2^(OUT_W−1) it clamps to the minimum.
  - The matching `out_sat` bit is 1 only for that frame.
  - `ACC_W` never overflows for frames of at most 2^`CNT_W` terms.
- **Output handshake.** The output register goes FULL to EMPTY on `out_valid && out_ready`. `out_a`, `out_b`, `out_cnt` and `out_sat` stay stable while `out_valid && !out_ready`.
- **Backpressure.** `in_ready = !out_valid || out_ready`. Pop and load in the same cycle are allowed; the new result replaces the popped one.
- **Reset.**
  - Asserting `rst` clears the accumulators, `cnt`, the output register and `out_valid`.
  - A partially accumulated frame is discarded.
  - No term is accepted in a cycle where `rst` is 1.

## Timing

- **Reset values.** `out_valid = 0`, `out_a = 0`, `out_b = 0`, `out_cnt = 0`, `out_sat = 2'b00`. `in_ready = 1` in the first cycle after reset.
- **Latency.** If the last term is accepted at edge k, then `out_valid = 1` with the result from edge k onward, i.e. during cycle k+1.
- **Throughput.** One term per cycle with `out_ready` held 1, including back-to-back single-term frames.
- **Stall.** While `out_valid && !out_ready`, `in_ready` is 0 and no terms are consumed, mid-frame or not. Accumulator contents are preserved.
- **Input behaviour.**
  - `in_data` and `in_last` are ignored when `in_valid` is 0.
  - `in_ready` has no combinational dependency on `in_valid`, `in_data` or `in_last`.

## Test plan

- **Basic decode, one term.** Send the product of D=3, WA=5, WB=−7, i.e. packed −1376241, as a single last term → `out_a = 15`, `out_b = −21`, `out_cnt = 1`, `out_sat = 00`, `out_valid` one cycle after acceptance.
- **Borrow correction.** Send the product of D=−128, WA=127, WB=1, i.e. low field 0xC080, as a single last term → `out_a = −16256`, `out_b = −128`.
- **Accumulation with saturation.** Send 3 terms of D=−128, WA=−128, WB=0, the last flagged → `out_a = 32767`, `out_b = 0`, `out_cnt = 3`, `out_sat = 01`. The following single-term frame with a=1 → `out_sat = 00`.
- **Backpressure.** Hold `out_ready = 0` after frame 1 completes → `in_ready = 0`, outputs stable for 10 cycles. Release it → `in_ready = 1` in the cycle `out_ready` is sampled. Frame 2 sums are correct, with no term lost or duplicated.
- **Streaming.** Send 8 back-to-back single-term frames with `out_ready = 1` → 8 results on consecutive cycles, each equal to its decoded input.
- **Reset mid-frame.** After 2 of 4 terms, assert `rst` for 1 cycle, then send a new 2-term frame of a=10, b=20 each → `out_a = 20`, `out_b = 40`, `out_cnt = 2`. `out_valid` is 0 during and immediately after reset.
